// File: rtl/imem_fetch.sv
// Instruction fetch front end: holds the fetch PC, addresses imem and buffers {pc, instr} in a prefetch FIFO for decode.
// Optional feature: define FETCH_MISALIGN_EN to trap misaligned redirect targets in a FAULT state.
module imem_fetch #(
    parameter int          N        = 32,
    parameter int          AW       = 6,
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] imem_addr,
    input  logic [N-1:0]  imem_q,
    input  logic          redirect_i,
    input  logic [63:0]   redirect_pc_i,
    output logic          inst_valid_o,
    input  logic          inst_ready_i,
    output logic [N-1:0]  inst_o,
    output logic [63:0]   inst_pc_o,
    output logic          fault_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [63:0]   fetch_pc, fetch_pc_nxt;
    logic [63:0]   target_pc;
    logic          push, pop, flush;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [N-1:0]  mem_instr [DEPTH];
    logic [63:0]   mem_pc    [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_EN
    assign target_pc = redirect_pc_i;
`else
    // Low bits are dropped so a misaligned target simply fetches its aligned word.
    assign target_pc = redirect_pc_i & ~64'd3;
`endif

    assign imem_addr    = fetch_pc[AW+1:2];
    assign inst_valid_o = (count != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = inst_valid_o ? mem_instr[rd_ptr] : '0;
    assign inst_pc_o    = inst_valid_o ? mem_pc[rd_ptr]    : '0;

`ifdef FETCH_MISALIGN_EN
    assign fault_o = (state == S_FAULT);
`else
    assign fault_o = 1'b0;
`endif

    // Redirect wins over fetch; a full FIFO may still push when the head leaves this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        if (redirect_i) begin
            flush        = 1'b1;
            fetch_pc_nxt = target_pc;
`ifdef FETCH_MISALIGN_EN
            state_nxt    = (target_pc[1:0] != 2'b00) ? S_FAULT : S_RUN;
`else
            state_nxt    = S_RUN;
`endif
        end else if (state == S_RUN && (count < DEPTH_C || pop)) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 64'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_q;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed self-checking bench for imem_fetch; the imem model returns 32'hA000_0000 | addr.
module tb_imem_fetch;

    localparam int AW = 6;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          redirect_i;
    logic [63:0]   redirect_pc_i;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic [31:0]   inst_o;
    logic [63:0]   inst_pc_o;
    logic          fault_o;

    int tests;
    int fails;

    imem_fetch #(.N(32), .AW(AW), .DEPTH(2), .RESET_PC(64'd0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .fault_o      (fault_o)
    );

    always_comb imem_q = 32'hA000_0000 | {26'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 64'd0;
        inst_ready_i  = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
        tests++; if (inst_o !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h expected 0", inst_o); end
        tests++; if (inst_pc_o !== 64'd0) begin fails++; $display("FAIL reset_pc: got %h expected 0", inst_pc_o); end
        tests++; if (fault_o !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
        reset_n = 1'b1;
        tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL release_valid: got %b expected 0", inst_valid_o); end
    endtask

    // Leaves the head at pc 8 with fetch_pc 12.
    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, inst_valid_o); end
            tests++; if (inst_pc_o !== 64'(4 * i)) begin fails++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, inst_pc_o, 4 * i); end
            tests++; if (inst_o !== (32'hA000_0000 | 32'(i))) begin fails++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, inst_o, 32'hA000_0000 | 32'(i)); end
        end
    endtask

    task automatic test_stall();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'h8 || inst_o !== 32'hA000_0002) begin
                fails++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h expected v=1 pc=8 i=a0000002", i, inst_valid_o, inst_pc_o, inst_o);
            end
            if (i >= 1) begin
                tests++; if (imem_addr !== 6'd4) begin fails++; $display("FAIL stall_addr[%0d]: got %0d expected 4", i, imem_addr); end
            end
        end
        inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'(12 + 4 * i)) begin
                fails++; $display("FAIL resume_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, inst_valid_o, inst_pc_o, 12 + 4 * i);
            end
            tests++; if (inst_o !== (32'hA000_0000 | 32'(3 + i))) begin fails++; $display("FAIL resume_inst[%0d]: got %h expected %h", i, inst_o, 32'hA000_0000 | 32'(3 + i)); end
        end
    endtask

    task automatic test_redirect();
        tests++; if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL redir_pre_valid: got %b expected 1", inst_valid_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 64'hD0;
        step();
        redirect_i = 1'b0;
        tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL redir_bubble: got %b expected 0", inst_valid_o); end
        tests++; if (imem_addr !== 6'h34) begin fails++; $display("FAIL redir_addr: got %h expected 34", imem_addr); end
        step();
        tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'hD0 || inst_o !== 32'hA000_0034) begin
            fails++; $display("FAIL redir_first: got v=%b pc=%h i=%h expected v=1 pc=d0 i=a0000034", inst_valid_o, inst_pc_o, inst_o);
        end
        step();
        tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'hD4 || inst_o !== 32'hA000_0035) begin
            fails++; $display("FAIL redir_second: got v=%b pc=%h i=%h expected v=1 pc=d4 i=a0000035", inst_valid_o, inst_pc_o, inst_o);
        end
    endtask

    task automatic test_wrap();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'hFC;
        step();
        redirect_i = 1'b0;
        tests++; if (imem_addr !== 6'd63) begin fails++; $display("FAIL wrap_addr_top: got %0d expected 63", imem_addr); end
        step();
        tests++; if (inst_pc_o !== 64'hFC || inst_o !== 32'hA000_003F) begin
            fails++; $display("FAIL wrap_head_fc: got pc=%h i=%h expected pc=fc i=a000003f", inst_pc_o, inst_o);
        end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL wrap_addr_zero: got %0d expected 0", imem_addr); end
        step();
        tests++; if (inst_pc_o !== 64'h100 || inst_o !== 32'hA000_0000) begin
            fails++; $display("FAIL wrap_head_100: got pc=%h i=%h expected pc=100 i=a0000000", inst_pc_o, inst_o);
        end
    endtask

    task automatic test_reset_mid();
        step();
        #2 reset_n = 1'b0;
        #1;
        tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", inst_valid_o); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL midrst_addr: got %0d expected 0", imem_addr); end
        tests++; if (inst_pc_o !== 64'd0 || inst_o !== 32'd0) begin fails++; $display("FAIL midrst_outs: got pc=%h i=%h expected 0", inst_pc_o, inst_o); end
        @(negedge clk);
        reset_n = 1'b1;
        tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_release: got %b expected 0", inst_valid_o); end
        test_stream();
    endtask

    task automatic test_back_to_back();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected 0", i, inst_valid_o); end
        end
        redirect_i = 1'b0;
        step();
        tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'h80 || inst_o !== 32'hA000_0020) begin
            fails++; $display("FAIL b2b_target: got v=%b pc=%h i=%h expected v=1 pc=80 i=a0000020", inst_valid_o, inst_pc_o, inst_o);
        end
    endtask

    task automatic test_misalign();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h42;
        step();
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_EN
        for (int i = 0; i < 3; i++) begin
            tests++; if (fault_o !== 1'b1 || inst_valid_o !== 1'b0) begin
                fails++; $display("FAIL fault_hold[%0d]: got f=%b v=%b expected f=1 v=0", i, fault_o, inst_valid_o);
            end
            step();
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h40;
        step();
        redirect_i = 1'b0;
        tests++; if (fault_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            fails++; $display("FAIL fault_exit: got f=%b v=%b expected f=0 v=0", fault_o, inst_valid_o);
        end
`else
        tests++; if (fault_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            fails++; $display("FAIL misalign_bubble: got f=%b v=%b expected f=0 v=0", fault_o, inst_valid_o);
        end
`endif
        step();
        tests++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 64'h40 || inst_o !== 32'hA000_0010 || fault_o !== 1'b0) begin
            fails++; $display("FAIL misalign_target: got v=%b pc=%h i=%h f=%b expected v=1 pc=40 i=a0000010 f=0", inst_valid_o, inst_pc_o, inst_o, fault_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
